// File: rtl/axi4_stream_fifo.sv
// Synchronous AXI4-Stream FIFO: RAM storage plus a registered output stage, full sideband carried.
// Define AXI4_STREAM_FIFO_PACKET_EN for store-and-forward gating with cut-through overflow fallback.
module axi4_stream_fifo #(
   parameter int N_BYTES     = 4,
   parameter int TID_WIDTH   = 4,
   parameter int TDEST_WIDTH = 0,
   parameter int TUSER_WIDTH = 0,
   parameter int DEPTH       = 16,
   localparam int CW  = $clog2(DEPTH + 1),
   localparam int IDW = (TID_WIDTH   > 0) ? TID_WIDTH   : 1,
   localparam int DSW = (TDEST_WIDTH > 0) ? TDEST_WIDTH : 1,
   localparam int UW  = (TUSER_WIDTH > 0) ? TUSER_WIDTH : 1
) (
   input  logic                   ACLK,
   input  logic                   ARESET,
   input  logic                   S_TVALID,
   output logic                   S_TREADY,
   input  logic [8*N_BYTES-1:0]   S_TDATA,
   input  logic [N_BYTES-1:0]     S_TSTRB,
   input  logic [N_BYTES-1:0]     S_TKEEP,
   input  logic                   S_TLAST,
   input  logic [IDW-1:0]         S_TID,
   input  logic [DSW-1:0]         S_TDEST,
   input  logic [UW-1:0]          S_TUSER,
   output logic                   M_TVALID,
   input  logic                   M_TREADY,
   output logic [8*N_BYTES-1:0]   M_TDATA,
   output logic [N_BYTES-1:0]     M_TSTRB,
   output logic [N_BYTES-1:0]     M_TKEEP,
   output logic                   M_TLAST,
   output logic [IDW-1:0]         M_TID,
   output logic [DSW-1:0]         M_TDEST,
   output logic [UW-1:0]          M_TUSER,
   output logic [CW-1:0]          COUNT,
   output logic                   OVERFLOW_CUT
);

   localparam int AW = $clog2(DEPTH);
   localparam int BW = 10 * N_BYTES + 1 + IDW + DSW + UW;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [BW-1:0] mem [DEPTH];
   logic [BW-1:0] wr_word;
   logic [BW-1:0] out_reg;
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic [CW-1:0] count_next;
   logic [CW-1:0] mem_cnt_reg;
   logic [CW-1:0] mem_cnt_next;
   logic          out_full_reg;
   logic          out_full_next;
   logic          s_ready_reg;
   logic          m_valid_reg;
   logic          m_valid_next;
   logic          wr;
   logic          rd;
   logic          load;
   logic          release_ok;

   assign wr      = S_TVALID && s_ready_reg;
   assign rd      = m_valid_reg && M_TREADY;
   // COUNT includes the beat parked in out_reg; mem_cnt tracks only what is still in RAM.
   assign load    = (mem_cnt_reg != '0) && (!out_full_reg || rd);
   assign wr_word = {S_TDATA, S_TSTRB, S_TKEEP, S_TLAST, S_TID, S_TDEST, S_TUSER};

   assign count_next    = count_reg + CW'(wr) - CW'(rd);
   assign mem_cnt_next  = mem_cnt_reg + CW'(wr) - CW'(load);
   assign out_full_next = load || (out_full_reg && !rd);
   assign m_valid_next  = out_full_next && release_ok;

   always_ff @(posedge ACLK) begin
      if (wr) begin
         mem[wr_ptr_reg] <= wr_word;
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         mem_cnt_reg  <= '0;
         out_full_reg <= 1'b0;
         s_ready_reg  <= 1'b0;
         m_valid_reg  <= 1'b0;
         out_reg      <= '0;
      end else begin
         count_reg    <= count_next;
         mem_cnt_reg  <= mem_cnt_next;
         out_full_reg <= out_full_next;
         m_valid_reg  <= m_valid_next;
         s_ready_reg  <= (count_next < FULL_CNT);
         if (wr) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (load) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
            out_reg    <= mem[rd_ptr_reg];
         end
      end
   end

`ifdef AXI4_STREAM_FIFO_PACKET_EN
   logic [CW-1:0] pkt_cnt_reg;
   logic [CW-1:0] pkt_cnt_next;
   logic          cut_reg;
   logic          cut_next;
   logic          cut_enter;
   logic          ovf_reg;
   logic          pkt_in;
   logic          pkt_out;

   assign pkt_in       = wr && S_TLAST;
   assign pkt_out      = rd && M_TLAST;
   assign pkt_cnt_next = pkt_cnt_reg + CW'(pkt_in) - CW'(pkt_out);
   // A full FIFO holding no complete packet can never drain by itself, so stream it through.
   assign cut_enter    = !cut_reg && (count_reg == FULL_CNT) && (pkt_cnt_reg == '0);
   assign cut_next     = cut_enter || (cut_reg && !pkt_out);
   assign release_ok   = cut_next || (pkt_cnt_reg > CW'(pkt_out));

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         pkt_cnt_reg <= '0;
         cut_reg     <= 1'b0;
         ovf_reg     <= 1'b0;
      end else begin
         pkt_cnt_reg <= pkt_cnt_next;
         cut_reg     <= cut_next;
         ovf_reg     <= cut_enter;
      end
   end

   assign OVERFLOW_CUT = ovf_reg;
`else
   assign release_ok   = 1'b1;
   assign OVERFLOW_CUT = 1'b0;
`endif

   assign S_TREADY = s_ready_reg;
   assign M_TVALID = m_valid_reg;
   assign COUNT    = count_reg;
   assign {M_TDATA, M_TSTRB, M_TKEEP, M_TLAST, M_TID, M_TDEST, M_TUSER} = out_reg;

endmodule

// File: tb/tb_axi4_stream_fifo.sv
// Randomized scoreboard bench for axi4_stream_fifo; a queue model predicts handshakes, COUNT and payload.
// Packet-mode expectations follow AXI4_STREAM_FIFO_PACKET_EN when it is defined for the build.
module tb_axi4_stream_fifo;

   localparam int DEPTH = 16;
`ifdef AXI4_STREAM_FIFO_PACKET_EN
   localparam bit PKT = 1'b1;
`else
   localparam bit PKT = 1'b0;
`endif

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic        S_TVALID;
   logic        S_TREADY;
   logic [31:0] S_TDATA;
   logic [3:0]  S_TSTRB;
   logic [3:0]  S_TKEEP;
   logic        S_TLAST;
   logic [3:0]  S_TID;
   logic [0:0]  S_TDEST;
   logic [0:0]  S_TUSER;
   logic        M_TVALID;
   logic        M_TREADY;
   logic [31:0] M_TDATA;
   logic [3:0]  M_TSTRB;
   logic [3:0]  M_TKEEP;
   logic        M_TLAST;
   logic [3:0]  M_TID;
   logic [0:0]  M_TDEST;
   logic [0:0]  M_TUSER;
   logic [4:0]  COUNT;
   logic        OVERFLOW_CUT;

   axi4_stream_fifo #(
      .N_BYTES(4), .TID_WIDTH(4), .TDEST_WIDTH(0), .TUSER_WIDTH(0), .DEPTH(DEPTH)
   ) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .S_TVALID(S_TVALID), .S_TREADY(S_TREADY), .S_TDATA(S_TDATA), .S_TSTRB(S_TSTRB),
      .S_TKEEP(S_TKEEP), .S_TLAST(S_TLAST), .S_TID(S_TID), .S_TDEST(S_TDEST), .S_TUSER(S_TUSER),
      .M_TVALID(M_TVALID), .M_TREADY(M_TREADY), .M_TDATA(M_TDATA), .M_TSTRB(M_TSTRB),
      .M_TKEEP(M_TKEEP), .M_TLAST(M_TLAST), .M_TID(M_TID), .M_TDEST(M_TDEST), .M_TUSER(M_TUSER),
      .COUNT(COUNT), .OVERFLOW_CUT(OVERFLOW_CUT)
   );

   always #5 ACLK = ~ACLK;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  strb;
      logic [3:0]  keep;
      logic        last;
      logic [3:0]  id;
      logic [0:0]  dest;
      logic [0:0]  user;
      int          wedge;
   } beat_t;

   beat_t q[$];
   int    n_checks = 0;
   int    n_fail = 0;
   int    edge_no = 0;
   bit    checking = 0;
   bit    after_reset = 0;
   bit    exp_ready = 0;
   bit    exp_ovf = 0;
   bit    cut_m = 0;
   bit    acc_flag = 0;

   int    seq_base = 0;
   bit    seq_data = 1;
   bit    side_mode = 0;
   int    last_mode = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at t=%0t", name, got, exp, $time);
      end
   endtask

   function automatic bit has_last();
      foreach (q[i]) if (q[i].last) return 1'b1;
      return 1'b0;
   endfunction

   // Head must have been written at least one edge ago; packet mode also needs a complete packet aged one edge.
   function automatic bit model_valid();
      if (q.size() == 0) return 1'b0;
      if (q[0].wedge > edge_no - 1) return 1'b0;
      if (!PKT || cut_m) return 1'b1;
      foreach (q[i]) if (q[i].last && q[i].wedge <= edge_no - 1) return 1'b1;
      return 1'b0;
   endfunction

   // Monitor: checks the state left by the last edge, then applies the coming edge to the model.
   always @(negedge ACLK) begin
      bit    exp_valid;
      bit    rd;
      bit    wr;
      bit    rd_last;
      bit    enter;
      beat_t b;
      #2;
      if (checking) begin
         exp_valid = model_valid();
         check("s_tready", 64'(S_TREADY), 64'(exp_ready));
         check("m_tvalid", 64'(M_TVALID), 64'(exp_valid));
         check("count", 64'(COUNT), 64'(q.size()));
         check("overflow_cut", 64'(OVERFLOW_CUT), 64'(exp_ovf));
         if (after_reset)
            check("reset_payload", 64'({M_TDATA, M_TSTRB, M_TKEEP, M_TLAST, M_TID, M_TDEST, M_TUSER}), 64'(0));
      end else begin
         exp_valid = 1'b0;
      end
      if (ARESET) begin
         q.delete();
         cut_m       = 1'b0;
         exp_ovf     = 1'b0;
         exp_ready   = 1'b0;
         acc_flag    = 1'b0;
         after_reset = 1'b1;
         checking    = 1'b1;
      end else if (checking) begin
         after_reset = 1'b0;
         enter   = PKT && !cut_m && (q.size() == DEPTH) && !has_last();
         rd      = exp_valid && M_TREADY;
         wr      = S_TVALID && exp_ready;
         acc_flag = wr;
         rd_last = 1'b0;
         if (rd) begin
            check("payload",
                  64'({M_TDATA, M_TSTRB, M_TKEEP, M_TLAST, M_TID, M_TDEST, M_TUSER}),
                  64'({q[0].data, q[0].strb, q[0].keep, q[0].last, q[0].id, q[0].dest, q[0].user}));
            $display("rd beat data=%08h strb=%h keep=%h last=%0d id=%h dest=%0d user=%0d count=%0d",
                     M_TDATA, M_TSTRB, M_TKEEP, M_TLAST, M_TID, M_TDEST, M_TUSER, COUNT);
            rd_last = q[0].last;
            void'(q.pop_front());
         end
         if (wr) begin
            b.data = S_TDATA; b.strb = S_TSTRB; b.keep = S_TKEEP; b.last = S_TLAST;
            b.id = S_TID; b.dest = S_TDEST; b.user = S_TUSER; b.wedge = edge_no + 1;
            q.push_back(b);
         end
         if (enter) cut_m = 1'b1;
         else if (cut_m && rd_last) cut_m = 1'b0;
         exp_ovf   = enter;
         exp_ready = (q.size() < DEPTH);
      end
      edge_no++;
   end

   task automatic set_beat(input int idx, input int n);
      S_TDATA = seq_data ? 32'(seq_base + idx) : 32'($urandom);
      S_TSTRB = 4'($urandom);
      S_TKEEP = 4'($urandom);
      S_TID   = 4'($urandom);
      S_TDEST = 1'($urandom);
      S_TUSER = 1'($urandom);
      case (last_mode)
         0:       S_TLAST = 1'b0;
         1:       S_TLAST = (idx == n - 1);
         2:       S_TLAST = 1'b1;
         default: S_TLAST = (idx == n - 1) || ($urandom_range(3) == 0);
      endcase
      if (side_mode && idx == 2) begin
         S_TID = 4'hA; S_TSTRB = 4'b0101; S_TKEEP = 4'b0111; S_TUSER = 1'b1; S_TLAST = 1'b1;
      end
   endtask

   task automatic run(input int n, input int vpct, input int rpct, input int max_cyc);
      int idx = 0;
      int cyc = 0;
      while (idx < n) begin
         if (!S_TVALID && $urandom_range(99) < vpct) begin
            set_beat(idx, n);
            S_TVALID = 1'b1;
         end
         M_TREADY = ($urandom_range(99) < rpct);
         @(negedge ACLK);
         if (S_TVALID && acc_flag) begin
            idx++;
            S_TVALID = 1'b0;
         end
         cyc++;
         if (cyc > max_cyc) begin
            n_checks++; n_fail++;
            $display("FAIL run_timeout: sent %0d beats, required %0d", idx, n);
            S_TVALID = 1'b0;
            break;
         end
      end
   endtask

   task automatic drain(input int max_cyc);
      int cyc = 0;
      S_TVALID = 1'b0;
      M_TREADY = 1'b1;
      while (q.size() != 0) begin
         @(negedge ACLK);
         cyc++;
         if (cyc > max_cyc) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout: %0d beats left, required 0", q.size());
            break;
         end
      end
      M_TREADY = 1'b0;
   endtask

   task automatic idle(input int n);
      S_TVALID = 1'b0;
      M_TREADY = 1'b0;
      repeat (n) @(negedge ACLK);
   endtask

   task automatic do_reset(input int n);
      ARESET   = 1'b1;
      S_TVALID = 1'b0;
      M_TREADY = 1'b0;
      repeat (n) @(negedge ACLK);
      ARESET = 1'b0;
   endtask

   initial begin
      ARESET = 1'b1; S_TVALID = 1'b0; M_TREADY = 1'b0;
      S_TDATA = '0; S_TSTRB = '0; S_TKEEP = '0; S_TLAST = 1'b0;
      S_TID = '0; S_TDEST = '0; S_TUSER = '0;
      @(negedge ACLK);
      do_reset(3);
      idle(3);
      // Fill to full with 0..15, then drain in order; one closing TLAST beat ends any cut-through.
      seq_data = 1; seq_base = 0; last_mode = 0;
      run(16, 100, 0, 400);
      idle(3);
      drain(200);
      last_mode = 1;
      run(1, 100, 100, 100);
      drain(100);
      // Steady simultaneous read/write at COUNT=8 across pointer wrap.
      seq_base = 100; last_mode = 2;
      run(8, 100, 0, 100);
      idle(2);
      seq_base = 200;
      run(20, 100, 100, 100);
      drain(100);
      // Sideband fidelity on beat 3.
      seq_data = 0; side_mode = 1; last_mode = 1;
      run(4, 100, 50, 200);
      drain(100);
      side_mode = 0;
      // Back-to-back 4-beat and 5-beat packets.
      seq_data = 1; seq_base = 300;
      run(4, 100, 100, 100);
      seq_base = 400;
      run(5, 100, 100, 100);
      drain(100);
      // Random traffic, including a back-pressured stretch that reaches full.
      seq_data = 0; last_mode = 3;
      run(200, 70, 60, 3000);
      drain(300);
      run(150, 90, 25, 3000);
      drain(300);
      // Reset with five beats stored, then a clean packet.
      seq_data = 1; seq_base = 500; last_mode = 0;
      run(5, 100, 0, 100);
      idle(1);
      do_reset(1);
      seq_base = 600; last_mode = 1;
      run(4, 100, 100, 100);
      drain(100);
      idle(3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      n_checks++; n_fail++;
      $display("FAIL watchdog: simulation still running at t=%0t, required completion earlier", $time);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/axi4_stream_fifo.md
Name: axi4_stream_fifo

Overview:
- Parametrised synchronous AXI4-Stream FIFO. Carries the full channel: TDATA, TSTRB, TKEEP, TLAST, TID, TDEST and TUSER.
- Sits between any AXI4-Stream master and slave on a single clock domain. Provides elastic buffering and optional store-and-forward packet gating.
- Sideband widths follow the stream channel rule: a width of 0 is carried as 1 bit, and the downstream slave ignores that bit.

Parameters:
- N_BYTES, 4, bytes per beat; TDATA is 8*N_BYTES bits, TSTRB/TKEEP are N_BYTES bits.
- TID_WIDTH, 4, TID width; 0 maps to 1.
- TDEST_WIDTH, 0, TDEST width; 0 maps to 1.
- TUSER_WIDTH, 0, TUSER width; 0 maps to 1.
- DEPTH, 16, number of beats stored; power of two, >= 2.
- CW, $clog2(DEPTH+1), width of the occupancy count (derived, not overridable).

Ports:
- ACLK  in  1  global clock; all logic on rising edge.
- ARESET  in  1  synchronous reset, active-high.
- S_TVALID/S_TREADY  in/out  1/1  slave-side handshake.
- S_TDATA, S_TSTRB, S_TKEEP, S_TLAST, S_TID, S_TDEST, S_TUSER  in  per parameters  slave-side payload.
- M_TVALID/M_TREADY  out/in  1/1  master-side handshake.
- M_TDATA, M_TSTRB, M_TKEEP, M_TLAST, M_TID, M_TDEST, M_TUSER  out  per parameters  master-side payload.
- COUNT  out  CW  beats currently stored, including the beat held on the M_ side.
- OVERFLOW_CUT  out  1  one-cycle pulse when packet-mode cut-through fallback fires; tied 0 when the packet feature is excluded.

Behaviour:
- Reset (ARESET=1 sampled at an edge):
  - S_TREADY=0, M_TVALID=0, COUNT=0, OVERFLOW_CUT=0.
  - Pointers cleared. All M_ payload outputs driven 0.
  - Reset mid-packet discards all stored beats; no partial-packet state survives.
- After reset: S_TREADY rises on the first edge with ARESET=0.
- Write:
  - Occurs when S_TVALID && S_TREADY at an edge.
  - S_TREADY is registered: it equals (COUNT_next < DEPTH).
  - There is no combinational path from M_TREADY to S_TREADY.
- Read:
  - Occurs when M_TVALID && M_TREADY at an edge.
  - M_ outputs are registered. Latency is 1 cycle: a beat written at edge N appears on M_ after edge N+1 if the FIFO was empty.
- Handshake rules:
  - Once M_TVALID=1, it and the M_ payload hold stable until the handshake completes.
  - M_TVALID never depends combinationally on M_TREADY.
- COUNT arithmetic:
  - COUNT_next = COUNT + write - read.
  - Simultaneous write and read leaves COUNT unchanged.
- Full (COUNT=DEPTH):
  - S_TREADY=0. A read in this cycle frees a slot; S_TREADY rises on the next edge.
  - No write is accepted in the full cycle.
- Empty (COUNT=0): M_TVALID=0, and the M_ payload holds its last value.
- Pointer wrap: read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full and empty are derived from COUNT, not from pointer equality.
- Payload fidelity: all fields are passed bit-exact, with no reordering or merging of beats.

Optional Feature:
- Macro: AXI4_STREAM_FIFO_PACKET_EN.
- Defined (store-and-forward):
  - A stored-packet counter increments on each write with S_TLAST=1 and decrements on each read with M_TLAST=1.
  - The counter handles a simultaneous increment and decrement.
  - M_TVALID is asserted only while the stored-packet counter is > 0.
- Defined (cut-through fallback):
  - If COUNT=DEPTH and the stored-packet counter is 0, the block enters a cut-through state and pulses OVERFLOW_CUT for one cycle.
  - In this state it releases beats regardless of TLAST.
  - It leaves this state on the read of a beat with M_TLAST=1.
- Not defined:
  - Pure FIFO behaviour: M_TVALID whenever COUNT > 0.
  - No packet counter logic; OVERFLOW_CUT tied 0.

Test Plan:
- Reset then idle: hold ARESET=1 for 3 cycles, release → S_TREADY=1 one edge later; M_TVALID=0, COUNT=0.
- Fill/drain, DEPTH=16, M_TREADY=0:
  - Write 16 beats TDATA=0..15 → S_TREADY=0 after the 16th, COUNT=16.
  - Assert M_TREADY → 16 beats out in order 0..15; S_TREADY back to 1 one cycle after the first read.
- Simultaneous read/write: COUNT=8, S_TVALID=M_TVALID handshakes both 1 for 20 cycles → COUNT stays 8; output sequence matches input across pointer wrap.
- Sideband fidelity: TID=0xA, TSTRB=0b0101, TKEEP=0b0111, TUSER=1, TLAST=1 on beat 3 → identical fields on M_ beat 3.
- Packet mode, 4-beat packet, TLAST on beat 4:
  - M_TVALID stays 0 through beats 1-3; rises 1 cycle after beat 4 is written.
  - 5-beat packet following on the input → not released until its TLAST.
- Packet mode overflow, DEPTH=16: write 16 beats with no TLAST → OVERFLOW_CUT pulses once; beats drain; normal gating resumes after the TLAST beat is read.
- Mid-stream reset: assert ARESET at COUNT=5 → next cycle COUNT=0, M_TVALID=0; a subsequent packet passes uncorrupted.
